// File: rtl/multi_bit_comparator_power_gated_pkg.sv
// Shared definitions for the power-gated magnitude comparator.
package multi_bit_comparator_power_gated_pkg;

   // Bit positions of the flags inside the {lt, eq, gt} result vector
   localparam int LT_POS = 2;
   localparam int EQ_POS = 1;
   localparam int GT_POS = 0;

   // One-hot compare result {lt, eq, gt}
   typedef logic [2:0] cmp_result_t;

   // Result register value while in reset
   localparam cmp_result_t CMP_RESET = 3'b000;

   // Pack the three chain flags into a result vector
   function automatic cmp_result_t pack_result(input logic lt, input logic eq, input logic gt);
      cmp_result_t res;
      res         = CMP_RESET;
      res[LT_POS] = lt;
      res[EQ_POS] = eq;
      res[GT_POS] = gt;
      return res;
   endfunction

endpackage

// File: rtl/multi_bit_comparator_power_gated_slice.sv
// One-bit compare cell with operand isolation: when any higher-order bit
// already differs, the cell's operands are forced to 0 so it cannot toggle.
module comparator_slice (
   input  logic a,
   input  logic b,
   input  logic eq_in,
   output logic lt,
   output logic gt,
   output logic eq_out
);

   logic a_iso_s;
   logic b_iso_s;

   // Isolate the operands and compute the per-bit flags
   always_comb begin
      a_iso_s = 1'b0;
      b_iso_s = 1'b0;
      lt      = 1'b0;
      gt      = 1'b0;
      eq_out  = 1'b0;
      if (eq_in) begin
         a_iso_s = a;
         b_iso_s = b;
         lt      = ~a_iso_s & b_iso_s;
         gt      = a_iso_s & ~b_iso_s;
         eq_out  = ~(a_iso_s ^ b_iso_s);
      end else begin
         a_iso_s = 1'b0;
         b_iso_s = 1'b0;
         lt      = 1'b0;
         gt      = 1'b0;
         eq_out  = 1'b0;
      end
   end

endmodule

// File: rtl/multi_bit_comparator_power_gated.sv
// Registered unsigned magnitude comparator with change-gated operand capture
// and an MSB-first chain of operand-isolated bit slices.
module multi_bit_comparator_power_gated
   import multi_bit_comparator_power_gated_pkg::*;
#(
   parameter int n = 3
) (
   input  logic       enable,
   input  logic       reset,
   input  logic [n:0] a_in,
   input  logic [n:0] b_in,
   output logic       less_than,
   output logic       equal_to,
   output logic       greater_than
);

   logic [n:0]   a_q_r;
   logic [n:0]   b_q_r;
   logic         load_s;
   logic [n+1:0] eq_chain_s;
   logic [n:0]   lt_vec_s;
   logic [n:0]   gt_vec_s;
   cmp_result_t  result_s;
   cmp_result_t  cmp_r;

   // Load strobe: capture only when either operand differs from its register
   always_comb begin
      load_s = 1'b0;
      if ((a_in != a_q_r) || (b_in != b_q_r)) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
   end

   // Operand capture registers, held unless an input changed
   always_ff @(posedge enable or negedge reset) begin
      if (!reset) begin
         a_q_r <= '0;
         b_q_r <= '0;
      end else if (load_s) begin
         a_q_r <= a_in;
         b_q_r <= b_in;
      end else begin
         a_q_r <= a_q_r;
         b_q_r <= b_q_r;
      end
   end

   // The MSB slice always sees "everything above is equal"
   assign eq_chain_s[n+1] = 1'b1;

   genvar gi;
   generate
      for (gi = n; gi >= 0; gi--) begin : g_slice
         comparator_slice u_slice (
            .a      (a_q_r[gi]),
            .b      (b_q_r[gi]),
            .eq_in  (eq_chain_s[gi+1]),
            .lt     (lt_vec_s[gi]),
            .gt     (gt_vec_s[gi]),
            .eq_out (eq_chain_s[gi])
         );
      end
   endgenerate

   // Reduce the slice flags into the combined compare result
   always_comb begin
      result_s = CMP_RESET;
      result_s = pack_result(|lt_vec_s, eq_chain_s[0], |gt_vec_s);
   end

   // Result register, refreshed on every edge outside reset
   always_ff @(posedge enable or negedge reset) begin
      if (!reset) begin
         cmp_r <= CMP_RESET;
      end else begin
         cmp_r <= result_s;
      end
   end

   assign less_than    = cmp_r[LT_POS];
   assign equal_to     = cmp_r[EQ_POS];
   assign greater_than = cmp_r[GT_POS];

endmodule

// File: tb/tb_multi_bit_comparator_power_gated.sv
// Directed bench for the power-gated comparator at n = 3 and n = 7.
module tb_multi_bit_comparator_power_gated;

   logic       clk;
   logic       rst_n;
   logic [3:0] a4;
   logic [3:0] b4;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       lt4, eq4, gt4;
   logic       lt8, eq8, gt8;

   int vectors;
   int miscompares;

   multi_bit_comparator_power_gated #(.n(3)) dut4 (
      .enable       (clk),
      .reset        (rst_n),
      .a_in         (a4),
      .b_in         (b4),
      .less_than    (lt4),
      .equal_to     (eq4),
      .greater_than (gt4)
   );

   multi_bit_comparator_power_gated #(.n(7)) dut8 (
      .enable       (clk),
      .reset        (rst_n),
      .a_in         (a8),
      .b_in         (b8),
      .less_than    (lt8),
      .equal_to     (eq8),
      .greater_than (gt8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past one rising edge, leaving time to sample away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a4 = 4'hA; b4 = 4'hB;
      a8 = 8'h12; b8 = 8'h34;
      #2;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({lt4, eq4, gt4} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_hold4 cycle %0d: got %b want 000", i, {lt4, eq4, gt4});
         end
         vectors++;
         if ({lt8, eq8, gt8} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_hold8 cycle %0d: got %b want 000", i, {lt8, eq8, gt8});
         end
         tick();
      end
      rst_n = 1'b1;
      tick();
      vectors++;
      if ({lt4, eq4, gt4} !== 3'b010) begin
         miscompares++;
         $display("FAIL reset_first_edge: got %b want 010", {lt4, eq4, gt4});
      end
   endtask

   task automatic test_less();
      // A/B were captured on the first post-reset edge
      tick();
      vectors++;
      if ({lt4, eq4, gt4} !== 3'b100) begin
         miscompares++;
         $display("FAIL less_A_B: got %b want 100", {lt4, eq4, gt4});
      end
   endtask

   task automatic test_equal();
      a4 = 4'h8; b4 = 4'h8;
      tick();
      vectors++;
      if ({lt4, eq4, gt4} !== 3'b100) begin
         miscompares++;
         $display("FAIL equal_latency: got %b want 100 (old result)", {lt4, eq4, gt4});
      end
      tick();
      vectors++;
      if ({lt4, eq4, gt4} !== 3'b010) begin
         miscompares++;
         $display("FAIL equal_8_8: got %b want 010", {lt4, eq4, gt4});
      end
   endtask

   task automatic test_msb();
      logic [2:0] iso_a;
      logic [2:0] iso_b;
      a4 = 4'h8; b4 = 4'h7;
      tick();
      tick();
      vectors++;
      if ({lt4, eq4, gt4} !== 3'b001) begin
         miscompares++;
         $display("FAIL msb_8_7: got %b want 001", {lt4, eq4, gt4});
      end
      iso_a = {dut4.g_slice[2].u_slice.a_iso_s, dut4.g_slice[1].u_slice.a_iso_s,
               dut4.g_slice[0].u_slice.a_iso_s};
      iso_b = {dut4.g_slice[2].u_slice.b_iso_s, dut4.g_slice[1].u_slice.b_iso_s,
               dut4.g_slice[0].u_slice.b_iso_s};
      vectors++;
      if ({iso_a, iso_b} !== 6'b000_000) begin
         miscompares++;
         $display("FAIL isolation_8_7: got a=%b b=%b want a=000 b=000", iso_a, iso_b);
      end
      a4 = 4'h0; b4 = 4'hF;
      tick();
      tick();
      vectors++;
      if ({lt4, eq4, gt4} !== 3'b100) begin
         miscompares++;
         $display("FAIL msb_0_F: got %b want 100", {lt4, eq4, gt4});
      end
   endtask

   task automatic test_gating();
      int loads;
      loads = 0;
      a4 = 4'h3; b4 = 4'h5;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (dut4.load_s === 1'b1) loads++;
         tick();
         if (i >= 1) begin
            vectors++;
            if ({lt4, eq4, gt4} !== 3'b100) begin
               miscompares++;
               $display("FAIL gating_hold edge %0d: got %b want 100", i, {lt4, eq4, gt4});
            end
         end
      end
      vectors++;
      if (loads !== 1) begin
         miscompares++;
         $display("FAIL gating_loads: got %0d want 1", loads);
      end
   endtask

   task automatic test_back_to_back();
      a4 = 4'h1; b4 = 4'h2;
      tick();
      a4 = 4'h2; b4 = 4'h1;
      tick();
      vectors++;
      if ({lt4, eq4, gt4} !== 3'b100) begin
         miscompares++;
         $display("FAIL b2b_first: got %b want 100", {lt4, eq4, gt4});
      end
      tick();
      vectors++;
      if ({lt4, eq4, gt4} !== 3'b001) begin
         miscompares++;
         $display("FAIL b2b_second: got %b want 001", {lt4, eq4, gt4});
      end
   endtask

   task automatic test_reset_mid();
      a4 = 4'h9; b4 = 4'h2;
      tick();
      tick();
      vectors++;
      if ({lt4, eq4, gt4} !== 3'b001) begin
         miscompares++;
         $display("FAIL mid_gt_before: got %b want 001", {lt4, eq4, gt4});
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({lt4, eq4, gt4} !== 3'b000) begin
         miscompares++;
         $display("FAIL mid_async_drop: got %b want 000", {lt4, eq4, gt4});
      end
      vectors++;
      if ({dut4.a_q_r, dut4.b_q_r} !== 8'h00) begin
         miscompares++;
         $display("FAIL mid_capture_clear: got %h want 00", {dut4.a_q_r, dut4.b_q_r});
      end
      rst_n = 1'b1;
      tick();
      vectors++;
      if ({lt4, eq4, gt4} !== 3'b010) begin
         miscompares++;
         $display("FAIL mid_first_edge: got %b want 010", {lt4, eq4, gt4});
      end
      tick();
      vectors++;
      if ({lt4, eq4, gt4} !== 3'b001) begin
         miscompares++;
         $display("FAIL mid_recover: got %b want 001", {lt4, eq4, gt4});
      end
   endtask

   task automatic test_width();
      logic [7:0] va [4];
      logic [7:0] vb [4];
      logic [2:0] ve [4];
      va[0] = 8'h80; vb[0] = 8'h7F; ve[0] = 3'b001;
      va[1] = 8'h7F; vb[1] = 8'h80; ve[1] = 3'b100;
      va[2] = 8'hFF; vb[2] = 8'hFF; ve[2] = 3'b010;
      va[3] = 8'h00; vb[3] = 8'h01; ve[3] = 3'b100;
      for (int i = 0; i < 4; i++) begin
         a8 = va[i]; b8 = vb[i];
         tick();
         tick();
         vectors++;
         if ({lt8, eq8, gt8} !== ve[i]) begin
            miscompares++;
            $display("FAIL width8 %h vs %h: got %b want %b", va[i], vb[i], {lt8, eq8, gt8}, ve[i]);
         end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      a4 = 4'h0; b4 = 4'h0;
      a8 = 8'h00; b8 = 8'h00;
      test_reset();
      test_less();
      test_equal();
      test_msb();
      test_gating();
      test_back_to_back();
      test_reset_mid();
      test_width();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
